// File: rtl/mem_map_pkg.sv
// Shared types and defaults for the MIPS memory-map controller.
// Holds the region and FSM encodings, default base addresses and the wait-counter width.
package mem_map_pkg;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] ROM_BASE_DEF = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE_DEF = 32'h1001_0000;
  localparam int          WAIT_W       = 4;

endpackage

// File: rtl/mem_map_decode.sv
// Combinational address decoder: classifies a byte address as ROM, RAM or unmapped.
// Also flags misalignment and ROM writes, and returns the byte offset from the hit region's base.
module mem_map_decode
  import mem_map_pkg::*;
#(
  parameter int                   BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] ROM_BASE  = BIT_WIDTH'(ROM_BASE_DEF),
  parameter logic [BIT_WIDTH-1:0] RAM_BASE  = BIT_WIDTH'(RAM_BASE_DEF),
  parameter int                   ROM_DEPTH = 256,
  parameter int                   RAM_DEPTH = 256
) (
  input  logic [BIT_WIDTH-1:0] addr,
  input  logic                 write,
  output region_t              region,
  output logic                 error,
  output logic [BIT_WIDTH-1:0] offset
);

  // Limits carry one extra bit so a region ending at the top of the address space cannot wrap.
  localparam logic [BIT_WIDTH:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [BIT_WIDTH:0] ROM_HI = ROM_LO + (BIT_WIDTH+1)'(4 * ROM_DEPTH);
  localparam logic [BIT_WIDTH:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [BIT_WIDTH:0] RAM_HI = RAM_LO + (BIT_WIDTH+1)'(4 * RAM_DEPTH);

  logic [BIT_WIDTH:0] addr_x;
  logic               rom_hit;
  logic               ram_hit;

  assign addr_x  = {1'b0, addr};
  assign rom_hit = (addr_x >= ROM_LO) && (addr_x < ROM_HI);
  assign ram_hit = (addr_x >= RAM_LO) && (addr_x < RAM_HI);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    region = REG_NONE;
    offset = '0;
    if (rom_hit) begin
      region = REG_ROM;
      offset = addr - ROM_BASE;
    end else if (ram_hit) begin
      region = REG_RAM;
      offset = addr - RAM_BASE;
    end
    error = (addr[1:0] != 2'b00) || (region == REG_NONE) || ((region == REG_ROM) && write);
  end

endmodule

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: sequences one ROM/RAM access at a time through IDLE/ACCESS/RESP
// with per-region wait states, a one-cycle Ready pulse and bus-error reporting.
module mem_map_ctrl
  import mem_map_pkg::*;
#(
  parameter int                   BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] ROM_BASE  = BIT_WIDTH'(ROM_BASE_DEF),
  parameter logic [BIT_WIDTH-1:0] RAM_BASE  = BIT_WIDTH'(RAM_BASE_DEF),
  parameter int                   ROM_DEPTH = 256,
  parameter int                   RAM_DEPTH = 256,
  parameter int                   ROM_WAIT  = 1,
  parameter int                   RAM_WAIT  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Req_in,
  input  logic                         Write_in,
  input  logic [BIT_WIDTH-1:0]         Address_in,
  input  logic [BIT_WIDTH-1:0]         Write_Data_in,
  output logic [BIT_WIDTH-1:0]         Read_Data_out,
  output logic                         Ready_out,
  output logic                         Error_out,
  output logic                         Busy_out,
  output logic [$clog2(ROM_DEPTH)-1:0] Rom_Index_out,
  input  logic [BIT_WIDTH-1:0]         Rom_Data_in,
  output logic [$clog2(RAM_DEPTH)-1:0] Ram_Index_out,
  input  logic [BIT_WIDTH-1:0]         Ram_Data_in,
  output logic [BIT_WIDTH-1:0]         Ram_Write_Data_out,
  output logic                         Ram_We_out
);

  localparam int ROM_IW = $clog2(ROM_DEPTH);
  localparam int RAM_IW = $clog2(RAM_DEPTH);

  region_t              dec_region;
  logic                 dec_error;
  logic [BIT_WIDTH-1:0] dec_offset;

  state_t               state;
  logic [WAIT_W-1:0]    count;
  logic                 write_q;
  region_t              region_q;

  mem_map_decode #(
    .BIT_WIDTH (BIT_WIDTH),
    .ROM_BASE  (ROM_BASE),
    .RAM_BASE  (RAM_BASE),
    .ROM_DEPTH (ROM_DEPTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_decode (
    .addr   (Address_in),
    .write  (Write_in),
    .region (dec_region),
    .error  (dec_error),
    .offset (dec_offset)
  );

  assign Busy_out = (state != IDLE);

  // The strobe is combinational so the array writes on the edge that closes the last ACCESS cycle.
  assign Ram_We_out = (state == ACCESS) && (count == '0) && write_q && (region_q == REG_RAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      count              <= '0;
      write_q            <= 1'b0;
      region_q           <= REG_NONE;
      Read_Data_out      <= '0;
      Ready_out          <= 1'b0;
      Error_out          <= 1'b0;
      Rom_Index_out      <= '0;
      Ram_Index_out      <= '0;
      Ram_Write_Data_out <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      Ready_out <= 1'b0;
      Error_out <= 1'b0;
      case (state)
        IDLE: begin
          if (Req_in) begin
            write_q            <= Write_in;
            region_q           <= dec_region;
            Ram_Write_Data_out <= Write_Data_in;
            Rom_Index_out      <= dec_offset[ROM_IW+1:2];
            Ram_Index_out      <= dec_offset[RAM_IW+1:2];
            if (dec_error) begin
              state     <= RESP;
              Ready_out <= 1'b1;
              Error_out <= 1'b1;
              if (!Write_in) Read_Data_out <= '0;
            end else begin
              state <= ACCESS;
              count <= (dec_region == REG_ROM) ? WAIT_W'(ROM_WAIT) : WAIT_W'(RAM_WAIT);
            end
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            if (!write_q) Read_Data_out <= (region_q == REG_ROM) ? Rom_Data_in : Ram_Data_in;
            state     <= RESP;
            Ready_out <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Self-checking bench for mem_map_ctrl: directed spec cases plus randomized accesses
// compared against an address-arithmetic reference model with its own RAM image.
module tb_mem_map_ctrl;
  import mem_map_pkg::*;

  localparam int          ROM_WAIT_P = 1;
  localparam int          RAM_WAIT_P = 2;
  localparam int          DEPTH      = 256;
  localparam longint      ROM_B      = 64'h0040_0000;
  localparam longint      RAM_B      = 64'h1001_0000;

  logic        clk;
  logic        rst_n;
  logic        Req_in;
  logic        Write_in;
  logic [31:0] Address_in;
  logic [31:0] Write_Data_in;
  logic [31:0] Read_Data_out;
  logic        Ready_out;
  logic        Error_out;
  logic        Busy_out;
  logic [7:0]  Rom_Index_out;
  logic [31:0] Rom_Data_in;
  logic [7:0]  Ram_Index_out;
  logic [31:0] Ram_Data_in;
  logic [31:0] Ram_Write_Data_out;
  logic        Ram_We_out;

  logic [31:0] rom_mem [DEPTH];
  logic [31:0] ram_arr [DEPTH];
  logic [31:0] ref_ram [DEPTH];
  logic [31:0] exp_rdata;
  int          total;
  int          bad;

  mem_map_ctrl #(
    .BIT_WIDTH (32),
    .ROM_BASE  (32'h0040_0000),
    .RAM_BASE  (32'h1001_0000),
    .ROM_DEPTH (DEPTH),
    .RAM_DEPTH (DEPTH),
    .ROM_WAIT  (ROM_WAIT_P),
    .RAM_WAIT  (RAM_WAIT_P)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .Req_in             (Req_in),
    .Write_in           (Write_in),
    .Address_in         (Address_in),
    .Write_Data_in      (Write_Data_in),
    .Read_Data_out      (Read_Data_out),
    .Ready_out          (Ready_out),
    .Error_out          (Error_out),
    .Busy_out           (Busy_out),
    .Rom_Index_out      (Rom_Index_out),
    .Rom_Data_in        (Rom_Data_in),
    .Ram_Index_out      (Ram_Index_out),
    .Ram_Data_in        (Ram_Data_in),
    .Ram_Write_Data_out (Ram_Write_Data_out),
    .Ram_We_out         (Ram_We_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Rom_Data_in = rom_mem[Rom_Index_out];
  assign Ram_Data_in = ram_arr[Ram_Index_out];
  always @(posedge clk) if (Ram_We_out) ram_arr[Ram_Index_out] <= Ram_Write_Data_out;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; expectations come from the address rules, not from the DUT.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    longint a;
    bit     rom_hit, ram_hit, err, got;
    int     idx, lat, we_cnt, we_cyc;
    a       = longint'(addr);
    rom_hit = (a >= ROM_B) && (a < ROM_B + 4 * DEPTH);
    ram_hit = (a >= RAM_B) && (a < RAM_B + 4 * DEPTH);
    err     = (a % 4 != 0) || !(rom_hit || ram_hit) || (rom_hit && wr);
    idx     = rom_hit ? int'((a - ROM_B) / 4) : int'((a - RAM_B) / 4);
    lat     = err ? 1 : 2 + (rom_hit ? ROM_WAIT_P : RAM_WAIT_P);

    Req_in = 1'b1; Write_in = wr; Address_in = addr; Write_Data_in = wd;
    @(posedge clk);
    got = 0; we_cnt = 0; we_cyc = 0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      if (Ram_We_out) begin we_cnt++; we_cyc = cyc; end
      if (Ready_out) begin
        got = 1;
        check("ready_cycle", cyc, lat);
      end else begin
        check("busy_in_access", {31'd0, Busy_out}, 32'd1);
      end
      if (hold && !got) begin
        Write_in = 1'b1; Address_in = 32'h1001_0000 + 32'($urandom_range(0, 255) * 4);
      end else begin
        Req_in = 1'b0;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);

    check("error_flag", {31'd0, Error_out}, {31'd0, err});
    if (!err && rom_hit) check("rom_index", {24'd0, Rom_Index_out}, 32'(idx));
    if (!err && ram_hit) check("ram_index", {24'd0, Ram_Index_out}, 32'(idx));
    if (!wr) exp_rdata = err ? 32'd0 : (rom_hit ? rom_mem[idx] : ref_ram[idx]);
    check("read_data", Read_Data_out, exp_rdata);
    if (wr && !err) begin
      ref_ram[idx] = wd;
      check("we_pulses", 32'(we_cnt), 32'd1);
      check("we_cycle", 32'(we_cyc), 32'(1 + RAM_WAIT_P));
      check("ram_wdata", Ram_Write_Data_out, wd);
    end else begin
      check("no_we", 32'(we_cnt), 32'd0);
    end

    @(negedge clk);
    Req_in = 1'b0; Write_in = 1'b0;
    check("idle_after_resp", {30'd0, Busy_out, Ready_out}, 32'd0);
  endtask

  logic [31:0] raddr;
  int          kind;

  initial begin
    total = 0; bad = 0; exp_rdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[i] = $urandom;
      ram_arr[i] = $urandom;
      ref_ram[i] = ram_arr[i];
    end
    rom_mem[2] = 32'hDEAD_BEEF;
    rst_n = 1'b0; Req_in = 1'b0; Write_in = 1'b0; Address_in = '0; Write_Data_in = '0;
    #1;
    check("rst_rdata", Read_Data_out, 32'd0);
    check("rst_flags", {27'd0, Ready_out, Error_out, Busy_out, Ram_We_out, 1'b0}, 32'd0);
    check("rst_idx", {16'd0, Rom_Index_out, Ram_Index_out}, 32'd0);
    check("rst_wdata", Ram_Write_Data_out, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the test plan, back to back.
    access(1'b0, 32'h0040_0008, 32'd0, 1'b0);
    access(1'b1, 32'h1001_0004, 32'hCAFE_F00D, 1'b0);
    access(1'b0, 32'h1001_0004, 32'd0, 1'b0);
    access(1'b0, 32'h2000_0000, 32'd0, 1'b0);
    access(1'b1, 32'h0040_0000, 32'h1111_2222, 1'b0);
    access(1'b0, 32'h1001_0002, 32'd0, 1'b0);
    access(1'b1, 32'h1001_03FC, 32'hA5A5_5A5A, 1'b0);
    access(1'b0, 32'h1001_03FC, 32'd0, 1'b0);
    access(1'b0, 32'h1001_0400, 32'd0, 1'b0);
    access(1'b0, 32'h0040_03FC, 32'd0, 1'b0);
    access(1'b0, 32'h0040_0400, 32'd0, 1'b0);
    access(1'b0, 32'h003F_FFFC, 32'd0, 1'b0);
    access(1'b1, 32'h1000_FFFC, 32'h3333_4444, 1'b0);
    access(1'b0, 32'h0040_0008, 32'd0, 1'b1);
    access(1'b1, 32'h1001_0020, 32'h7777_8888, 1'b1);

    // Randomized traffic across all address classes.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       raddr = 32'(ROM_B) + 32'($urandom_range(0, 255) * 4);
        1:       raddr = 32'(RAM_B) + 32'($urandom_range(0, 255) * 4);
        2:       raddr = 32'(RAM_B) + 32'($urandom_range(0, 1023)) | 32'd1;
        3:       raddr = $urandom;
        4:       raddr = 32'(ROM_B) + 32'd1024 - 32'($urandom_range(0, 2) * 4);
        default: raddr = 32'(RAM_B) + 32'd1024 - 32'($urandom_range(0, 2) * 4);
      endcase
      access(1'($urandom_range(0, 1)), raddr, $urandom, 1'b0);
    end

    // Asynchronous reset during a RAM write wait state.
    Req_in = 1'b1; Write_in = 1'b1; Address_in = 32'h1001_0010; Write_Data_in = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    Req_in = 1'b0;
    check("abort_busy_before", {31'd0, Busy_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_rdata = 32'd0;
    check("abort_flags", {28'd0, Ready_out, Error_out, Busy_out, Ram_We_out}, 32'd0);
    check("abort_rdata", Read_Data_out, exp_rdata);
    check("abort_idx", {16'd0, Rom_Index_out, Ram_Index_out}, 32'd0);
    check("abort_wdata", Ram_Write_Data_out, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      check("abort_quiet", {29'd0, Ready_out, Busy_out, Ram_We_out}, 32'd0);
    end
    check("abort_ram_kept", ram_arr[4], ref_ram[4]);
    access(1'b0, 32'h1001_0010, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
